// File: rtl/alu_sched_pkg.sv
// Shared opcode, flag-index and helper definitions for the ALU issue scheduler
// and the other users of the integer ALU encoding.
package alu_sched_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_CMP   = 4'b1010;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b1100;
  localparam logic [3:0] OP_XOR   = 4'b0001;
  localparam logic [3:0] OP_PASSB = 4'b1101;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Only arithmetic ops produce meaningful carry/overflow; the ALU holds c/v otherwise.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr modulo N,
// plus the pointer value to load after this cycle.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  logic w_found;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loops leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    w_found  = 1'b0;
    // First pass covers ptr..N-1, second wraps around to 0..ptr-1.
    for (int j = 0; j < N; j++) begin
      if (en && !w_found && req[j] && (j >= int'(ptr))) begin
        grant[j] = 1'b1;
        w_found  = 1'b1;
        next_ptr = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (en && !w_found && req[j] && (j < int'(ptr))) begin
        grant[j] = 1'b1;
        w_found  = 1'b1;
        next_ptr = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Shares one integer ALU between reservation-station entries: round-robin issue,
// one-deep registered result stage on a valid/ready CDB port, flush, perf counters.
module alu_issue_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XLEN = 32,
  parameter int TAGW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]      req_grant,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_op,
  input  logic [XLEN-1:0]      alu_s,
  input  logic                 alu_z,
  input  logic                 alu_n,
  input  logic                 alu_c,
  input  logic                 alu_v,
  output logic                 cdb_valid,
  output logic [XLEN-1:0]      cdb_data,
  output logic [TAGW-1:0]      cdb_tag,
  output logic [3:0]           cdb_flags,
  input  logic                 cdb_ready,
  input  logic                 flush,
  output logic [15:0]          issue_cnt,
  output logic [15:0]          stall_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic            r_cdb_valid;
  logic [XLEN-1:0] r_cdb_data;
  logic [TAGW-1:0] r_cdb_tag;
  logic [3:0]      r_cdb_flags;
  logic [15:0]     r_issue_cnt;
  logic [15:0]     r_stall_cnt;

  logic [PW-1:0]   w_next_ptr;
  logic [NREQ-1:0] w_grant;
  logic            w_en;
  logic            w_any;
  logic [XLEN-1:0] w_sel_a;
  logic [XLEN-1:0] w_sel_b;
  logic [3:0]      w_sel_op;
  logic [TAGW-1:0] w_sel_tag;
  logic [3:0]      w_flags;

  assign w_en = !flush && (!r_cdb_valid || cdb_ready);

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req      (req_valid),
    .en       (w_en),
    .ptr      (r_ptr),
    .grant    (w_grant),
    .next_ptr (w_next_ptr)
  );

  assign w_any = |w_grant;

  // AND-OR mux on the one-hot grant keeps the operand path shallow; idle selects zero.
  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_op  = '0;
    w_sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a   = w_sel_a   | req_a[i*XLEN +: XLEN];
        w_sel_b   = w_sel_b   | req_b[i*XLEN +: XLEN];
        w_sel_op  = w_sel_op  | req_op[i*4 +: 4];
        w_sel_tag = w_sel_tag | req_tag[i*TAGW +: TAGW];
      end
    end
  end

  assign req_grant = w_grant;
  assign alu_a     = w_sel_a;
  assign alu_b     = w_sel_b;
  assign alu_op    = w_any ? w_sel_op : OP_NOP;

  always_comb begin
    w_flags        = '0;
    w_flags[FLG_Z] = alu_z;
    w_flags[FLG_N] = alu_n;
    w_flags[FLG_C] = alu_c && is_arith(alu_op);
    w_flags[FLG_V] = alu_v && is_arith(alu_op);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_valid <= 1'b0;
      r_cdb_data  <= '0;
      r_cdb_tag   <= '0;
      r_cdb_flags <= '0;
    end else if (w_any) begin
      r_cdb_valid <= 1'b1;
      r_cdb_data  <= alu_s;
      r_cdb_tag   <= w_sel_tag;
      r_cdb_flags <= w_flags;
    end else if (flush || cdb_ready) begin
      r_cdb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_ptr <= w_next_ptr;
      if (w_any)
        r_issue_cnt <= r_issue_cnt + 16'd1;
      if (|req_valid && !w_any)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_data  = r_cdb_data;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_flags = r_cdb_flags;
  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule
